// File: rtl/gpio_input_filter.sv
// GPIO pad input conditioning: synchronizer, debounce, and edge-event pulses per pin.
// Define GPIO_FILTER_IRQ_EN to add sticky pending bits and an interrupt output.
module gpio_input_filter #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   localparam int unsigned CNT_W          =
      (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1
) (
   input  logic             io_clock,
   input  logic             io_reset,
   input  logic [WIDTH-1:0] io_pins_raw,
   input  logic [WIDTH-1:0] io_pins_writeEnable,
`ifdef GPIO_FILTER_IRQ_EN
   input  logic [WIDTH-1:0] io_irqClear,
   output logic             io_irq,
`endif
   output logic [WIDTH-1:0] io_pins_read,
   output logic [WIDTH-1:0] io_rise,
   output logic [WIDTH-1:0] io_fall
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync;
   logic [WIDTH-1:0]                  read_d, read_q;
   logic [WIDTH-1:0]                  rise_d, rise_q;
   logic [WIDTH-1:0]                  fall_d, fall_q;

   // Plain flop chain; stage 0 is the only one that sees the asynchronous pad level.
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], io_pins_raw};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign read_d = sync;
   end else begin : g_debounce
      localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_d, cnt_q;

      always_comb begin
         cnt_d  = cnt_q;
         read_d = read_q;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == read_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
               read_d[i] = sync[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end

      always_ff @(posedge io_clock) begin
         if (io_reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   // Events are computed from the level update itself so each pulse lines up with the new level.
   assign rise_d = read_d & ~read_q & ~io_pins_writeEnable;
   assign fall_d = ~read_d & read_q & ~io_pins_writeEnable;

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         read_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         read_q <= read_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign io_pins_read = read_q;
   assign io_rise      = rise_q;
   assign io_fall      = fall_q;

`ifdef GPIO_FILTER_IRQ_EN
   logic [WIDTH-1:0] pending_d, pending_q;
   logic             irq_q;

   // A new event on the same cycle as a clear keeps the pin pending.
   assign pending_d = (pending_q & ~io_irqClear) | rise_q | fall_q;

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         pending_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         irq_q     <= |pending_q;
      end
   end

   assign io_irq = irq_q;
`endif

endmodule

// File: tb/tb_gpio_input_filter.sv
// Bench for gpio_input_filter: directed scenarios plus randomized pad activity
// checked against a sliding-window reference model.
module tb_gpio_input_filter;

   localparam int W = 4;
   localparam int S = 2;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] raw = '0;
   logic [W-1:0] we  = '0;
   logic [W-1:0] rd, rise, fall;
`ifdef GPIO_FILTER_IRQ_EN
   logic [W-1:0] clr = '0;
   logic         irq;
`endif

   int total = 0;
   int bad   = 0;

   gpio_input_filter #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .io_clock            (clk),
      .io_reset            (rst),
      .io_pins_raw         (raw),
      .io_pins_writeEnable (we),
`ifdef GPIO_FILTER_IRQ_EN
      .io_irqClear         (clr),
      .io_irq              (irq),
`endif
      .io_pins_read        (rd),
      .io_rise             (rise),
      .io_fall             (fall)
   );

   always #5 clk = ~clk;

   // Reference: hist[0] is the newest raw sample; the synchronizer output seen at an edge is
   // hist[S-1]. The level flips once the last D sync samples all disagree with it.
   logic [W-1:0] hist [S+D];
   logic [W-1:0] m_read = '0, m_rise = '0, m_fall = '0;
`ifdef GPIO_FILTER_IRQ_EN
   logic [W-1:0] m_pend = '0;
   logic         m_irq  = 1'b0;
`endif

   task automatic model_edge();
      logic [W-1:0] nxt;
      bit           steady;
      if (rst) begin
         for (int k = 0; k < S + D; k++) hist[k] = '0;
         m_read = '0;
         m_rise = '0;
         m_fall = '0;
`ifdef GPIO_FILTER_IRQ_EN
         m_pend = '0;
         m_irq  = 1'b0;
`endif
      end else begin
         nxt = m_read;
         for (int i = 0; i < W; i++) begin
            if (D == 0) begin
               nxt[i] = hist[S-1][i];
            end else begin
               steady = 1'b1;
               for (int k = 0; k < D; k++) if (hist[S-1+k][i] == m_read[i]) steady = 1'b0;
               if (steady) nxt[i] = ~m_read[i];
            end
         end
`ifdef GPIO_FILTER_IRQ_EN
         m_irq  = |m_pend;
         m_pend = (m_pend & ~clr) | m_rise | m_fall;
`endif
         m_rise = nxt & ~m_read & ~we;
         m_fall = ~nxt & m_read & ~we;
         m_read = nxt;
         for (int k = S + D - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = raw;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      raw = '0;
      we  = '0;
      repeat (3) step();
      total += 3;
      if (rd !== 4'b0000) begin bad++; $display("FAIL reset_read: got %b want 0000", rd); end
      if (rise !== 4'b0000) begin bad++; $display("FAIL reset_rise: got %b want 0000", rise); end
      if (fall !== 4'b0000) begin bad++; $display("FAIL reset_fall: got %b want 0000", fall); end
`ifdef GPIO_FILTER_IRQ_EN
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_clean_rise();
      raw[0] = 1'b1;
      for (int j = 0; j < 25; j++) begin
         step();
         total += 3;
         if (rd[0] !== (j >= 17))
            begin bad++; $display("FAIL rise_read j=%0d: got %b want %b", j, rd[0], j >= 17); end
         if (rise[0] !== (j == 17))
            begin bad++; $display("FAIL rise_pulse j=%0d: got %b want %b", j, rise[0], j == 17); end
         if (fall !== 4'b0000)
            begin bad++; $display("FAIL rise_nofall j=%0d: got %b want 0000", j, fall); end
      end
   endtask

   task automatic test_glitch();
      int lens [3] = '{10, 15, 16};
      int nr, nf;
      bit went_high;
      for (int t = 0; t < 3; t++) begin
         nr = 0;
         nf = 0;
         went_high = 1'b0;
         raw[1] = 1'b1;
         for (int j = 0; j < lens[t] + 40; j++) begin
            if (j == lens[t]) raw[1] = 1'b0;
            step();
            nr += int'(rise[1]);
            nf += int'(fall[1]);
            if (rd[1]) went_high = 1'b1;
         end
         total += 3;
         if (went_high !== (lens[t] >= 16))
            begin bad++; $display("FAIL glitch_level len=%0d: got %b want %b",
                                  lens[t], went_high, lens[t] >= 16); end
         if (nr != int'(lens[t] >= 16))
            begin bad++; $display("FAIL glitch_rises len=%0d: got %0d", lens[t], nr); end
         if (nf != int'(lens[t] >= 16))
            begin bad++; $display("FAIL glitch_falls len=%0d: got %0d", lens[t], nf); end
      end
   endtask

   task automatic test_writeenable();
      we[2]  = 1'b1;
      raw[2] = 1'b1;
      for (int j = 0; j < 25; j++) begin
         step();
         total += 2;
         if (rd[2] !== (j >= 17))
            begin bad++; $display("FAIL we_read j=%0d: got %b want %b", j, rd[2], j >= 17); end
         if (rise[2] !== 1'b0)
            begin bad++; $display("FAIL we_rise j=%0d: got %b want 0", j, rise[2]); end
      end
      we[2]  = 1'b0;
      raw[2] = 1'b0;
      for (int j = 0; j < 25; j++) begin
         step();
         total += 2;
         if (rd[2] !== (j < 17))
            begin bad++; $display("FAIL we_fall_read j=%0d: got %b want %b", j, rd[2], j < 17); end
         if (fall[2] !== (j == 17))
            begin bad++; $display("FAIL we_fall j=%0d: got %b want %b", j, fall[2], j == 17); end
      end
   endtask

   task automatic test_reset_mid();
      raw[3] = 1'b1;
      repeat (12) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total += 2;
      if (rd !== 4'b0000) begin bad++; $display("FAIL midrst_read: got %b want 0000", rd); end
      if (rise !== 4'b0000) begin bad++; $display("FAIL midrst_rise: got %b want 0000", rise); end
      for (int j = 0; j < 21; j++) begin
         step();
         total += 2;
         if (rd[3] !== (j >= 17))
            begin bad++; $display("FAIL midrst_level j=%0d: got %b want %b", j, rd[3], j >= 17); end
         if (rise[3] !== (j == 17))
            begin bad++; $display("FAIL midrst_pulse j=%0d: got %b want %b", j, rise[3], j == 17); end
      end
   endtask

   task automatic test_random();
      int hold [W];
      for (int i = 0; i < W; i++) hold[i] = 0;
      for (int c = 0; c < 900; c++) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               raw[i]  = ~raw[i];
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15)
                                                     : $urandom_range(10, 40);
            end else begin
               hold[i]--;
            end
         end
         if (c % 37 == 0) we = W'($urandom);
         rst = (c >= 450 && c < 453);
         step();
         total += 4;
         if (rd !== m_read)
            begin bad++; $display("FAIL rand_read c=%0d: got %b want %b", c, rd, m_read); end
         if (rise !== m_rise)
            begin bad++; $display("FAIL rand_rise c=%0d: got %b want %b", c, rise, m_rise); end
         if (fall !== m_fall)
            begin bad++; $display("FAIL rand_fall c=%0d: got %b want %b", c, fall, m_fall); end
         if ((rise & fall) !== 4'b0000)
            begin bad++; $display("FAIL rand_both c=%0d: got %b want 0000", c, rise & fall); end
      end
      rst = 1'b0;
   endtask

`ifdef GPIO_FILTER_IRQ_EN
   task automatic test_irq();
      raw = '0;
      we  = '0;
      clr = '1;
      repeat (50) step();
      clr = '0;
      total += 2;
      if (rd !== 4'b0000) begin bad++; $display("FAIL irq_settle_read: got %b want 0000", rd); end
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_settle: got %b want 0", irq); end
      raw[0] = 1'b1;
      for (int j = 0; j < 22; j++) begin
         step();
         total += 2;
         if (irq !== (j >= 19))
            begin bad++; $display("FAIL irq_set j=%0d: got %b want %b", j, irq, j >= 19); end
         if (irq !== m_irq)
            begin bad++; $display("FAIL irq_model j=%0d: got %b want %b", j, irq, m_irq); end
      end
      raw[0] = 1'b0;
      for (int j = 0; j < 23; j++) begin
         clr = (j == 18 || j == 19) ? 4'b0001 : 4'b0000;
         step();
         total += 2;
         if (irq !== (j < 20))
            begin bad++; $display("FAIL irq_clear j=%0d: got %b want %b", j, irq, j < 20); end
         if (fall[0] !== (j == 17))
            begin bad++; $display("FAIL irq_fall j=%0d: got %b want %b", j, fall[0], j == 17); end
      end
      clr = '0;
   endtask
`endif

   initial begin
      for (int k = 0; k < S + D; k++) hist[k] = '0;
      test_reset();
      test_clean_rise();
      test_glitch();
      test_writeenable();
      test_reset_mid();
      test_random();
`ifdef GPIO_FILTER_IRQ_EN
      test_irq();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
